demod_corr_stream: RTL and testbench

//  Streaming, parametrised successor to the fully unrolled Q16.16 demodulator.

---
 rtl/demod_pkg.sv | 39 +++
 rtl/demod_mac.sv | 79 +++++++
 rtl/demod_corr_stream.sv | 118 +++++++++++
 tb/tb_demod_corr_stream.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demod_pkg.sv
// Shared types, Q-format constants and the saturating add helper for the
// streaming correlator. sat_add is only referenced when DEMOD_SAT_EN is defined.
package demod_pkg;

   localparam int FRAC_W_DEF = 16;

   typedef enum logic [1:0] {
      ACC   = 2'd0,
      DRAIN = 2'd1,
      OUT   = 2'd2
   } state_t;

   // 1.0 in a Q format with frac_w fractional bits, held in 64 bits.
   function automatic logic signed [63:0] q_one(input int frac_w);
      return 64'sd1 <<< frac_w;
   endfunction

   localparam logic signed [63:0] ONE_Q     = q_one(FRAC_W_DEF);
   localparam logic signed [63:0] NEG_ONE_Q = -ONE_Q;

   // Adds two sign-extended w-bit values and clamps to the w-bit signed range.
   // Bit 64 of the result flags that a clamp happened; w must not exceed 64.
   function automatic logic [64:0] sat_add(input logic signed [63:0] a,
                                           input logic signed [63:0] b,
                                           input int w);
      logic signed [64:0] sum;
      logic signed [64:0] hi;
      logic signed [64:0] lo;
      logic [64:0]        res;
      sum = {a[63], a} + {b[63], b};
      hi  = (65'sd1 <<< (w - 1)) - 65'sd1;
      lo  = -(65'sd1 <<< (w - 1));
      if (sum > hi)      res = {1'b1, hi[63:0]};
      else if (sum < lo) res = {1'b1, lo[63:0]};
      else               res = {1'b0, sum[63:0]};
      return res;
   endfunction

endpackage

// File: rtl/demod_mac.sv
// Two-stage multiply/shift/accumulate datapath. Stage 1 registers the scaled
// product on an accept, stage 2 folds it into the accumulator one cycle later.
// acc_next/sat_next are exposed so the owner can capture the value that
// includes the final product on the same edge it lands.
// Optional build macro: DEMOD_SAT_EN (saturating add with sticky flag).
module demod_mac
   import demod_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int FRAC_W = 16,
   parameter int ACC_W  = 48
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              clr,
   output logic [ACC_W-1:0]  acc_next,
   output logic              sat_next
);

   localparam int PW = 2 * DATA_W;

   logic [ACC_W-1:0] prod_q;
   logic             prod_vld;
   logic [ACC_W-1:0] acc;
   logic             sat;

   // Stage 1: full-width signed product, floor shift, resize to accumulator width.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prod_q   <= '0;
         prod_vld <= 1'b0;
      end else begin
         prod_vld <= en;
         if (en) prod_q <= ACC_W'((PW'($signed(a)) * PW'($signed(b))) >>> FRAC_W);
      end
   end

`ifdef DEMOD_SAT_EN
   logic [64:0] sum_sat;

   // Stage 2 next value: clamped add with sticky saturation flag.
   always_comb begin
      acc_next = acc;
      sat_next = sat;
      sum_sat  = '0;
      if (clr) begin
         acc_next = '0;
         sat_next = 1'b0;
      end else if (prod_vld) begin
         sum_sat  = sat_add(64'($signed(acc)), 64'($signed(prod_q)), ACC_W);
         acc_next = ACC_W'(sum_sat[63:0]);
         sat_next = sat | sum_sat[64];
      end
   end
`else
   // Stage 2 next value: plain wrapping add, no saturation tracking.
   always_comb begin
      acc_next = acc;
      sat_next = 1'b0;
      if (clr)           acc_next = '0;
      else if (prod_vld) acc_next = acc + prod_q;
   end
`endif

   // Stage 2 accumulator and flag registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc <= '0;
         sat <= 1'b0;
      end else begin
         acc <= acc_next;
         sat <= sat_next;
      end
   end

endmodule

// File: rtl/demod_corr_stream.sv
// Streaming correlator: multiplies each accepted segment by a programmable
// per-index reference, accumulates SEG_N products and presents one symbol
// (accumulator, threshold decision, saturation flag) per valid/ready handshake.
// Optional build macro: DEMOD_SAT_EN (saturating accumulator, out_sat live).
//
//   state | meaning
//   ACC   | accepting segments, seg_idx selects the reference
//   DRAIN | last product lands in the accumulator, result captured
//   OUT   | symbol presented, waiting for out_ready
module demod_corr_stream
   import demod_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int FRAC_W = 16,
   parameter int SEG_N  = 10,
   parameter int ACC_W  = 48
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     ref_we,
   input  logic [$clog2(SEG_N)-1:0] ref_addr,
   input  logic [DATA_W-1:0]        ref_wdata,
   input  logic [ACC_W-1:0]         thresh,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ACC_W-1:0]         out_acc,
   output logic                     out_bit,
   output logic                     out_sat
);

   localparam int AW = $clog2(SEG_N);
   localparam logic [63:0] POS64 = q_one(FRAC_W);
   localparam logic [63:0] NEG64 = -POS64;
   localparam logic [DATA_W-1:0] REF_POS = POS64[DATA_W-1:0];
   localparam logic [DATA_W-1:0] REF_NEG = NEG64[DATA_W-1:0];

   state_t            state;
   logic [AW-1:0]     seg_idx;
   logic [DATA_W-1:0] ref_tbl [SEG_N];
   logic              accept;
   logic              clr;
   logic [ACC_W-1:0]  acc_next;
   logic              sat_next;

   assign accept = in_valid && in_ready;
   assign clr    = out_valid && out_ready;

   // Reference table: alternating +1.0/-1.0 after reset, writable at any time.
   // The multiplier reads the registered entry, so a same-cycle write is seen next time.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < SEG_N; k++) ref_tbl[k] <= (k % 2 == 0) ? REF_POS : REF_NEG;
      end else if (ref_we && (int'(ref_addr) < SEG_N)) begin
         ref_tbl[ref_addr] <= ref_wdata;
      end
   end

   demod_mac #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk      (clk),
      .reset    (reset),
      .en       (accept),
      .a        (in_data),
      .b        (ref_tbl[seg_idx]),
      .clr      (clr),
      .acc_next (acc_next),
      .sat_next (sat_next)
   );

   // Symbol sequencing with registered handshake and result outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ACC;
         seg_idx   <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_acc   <= '0;
         out_bit   <= 1'b0;
         out_sat   <= 1'b0;
      end else begin
         case (state)
            ACC: begin
               if (accept) begin
                  if (seg_idx == AW'(SEG_N - 1)) begin
                     seg_idx  <= '0;
                     in_ready <= 1'b0;
                     state    <= DRAIN;
                  end else begin
                     seg_idx <= seg_idx + 1'b1;
                  end
               end
            end
            DRAIN: begin
               out_acc   <= acc_next;
               out_bit   <= $signed(acc_next) > $signed(thresh);
               out_sat   <= sat_next;
               out_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ACC;
               end
            end
            default: state <= ACC;
         endcase
      end
   end

endmodule

// File: tb/tb_demod_corr_stream.sv
// Scoreboard bench for demod_corr_stream: the stimulus side computes each
// symbol from a table-level reference model and queues it; a monitor compares
// every presented symbol against the queue head and pops on the handshake.
module tb_demod_corr_stream;
   import demod_pkg::*;

   localparam int DATA_W = 32;
   localparam int FRAC_W = 16;
   localparam int SEG_N  = 10;
   localparam int ACC_W  = 48;
   localparam int AW     = $clog2(SEG_N);
   localparam logic [31:0] Q1  = 32'h0001_0000;
   localparam logic [31:0] QM1 = 32'hFFFF_0000;

   logic              clk;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              ref_we;
   logic [AW-1:0]     ref_addr;
   logic [DATA_W-1:0] ref_wdata;
   logic [ACC_W-1:0]  thresh;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_acc;
   logic              out_bit;
   logic              out_sat;

   demod_corr_stream #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .SEG_N  (SEG_N),
      .ACC_W  (ACC_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .ref_we    (ref_we),
      .ref_addr  (ref_addr),
      .ref_wdata (ref_wdata),
      .thresh    (thresh),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_acc   (out_acc),
      .out_bit   (out_bit),
      .out_sat   (out_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      longint acc;
      bit     b;
      bit     sat;
   } exp_t;

   exp_t   exp_q[$];
   int     checks   = 0;
   int     passed   = 0;
   int     n_pushed = 0;
   int     n_out    = 0;
   bit     hold_ready = 1'b0;

   longint mref [SEG_N];
   int     midx;
   longint macc;
   bit     msat;
   longint mthresh;

   localparam longint ACC_MAX = (64'sd1 <<< (ACC_W - 1)) - 1;
   localparam longint ACC_MIN = -(64'sd1 <<< (ACC_W - 1));

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act == req) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   function automatic longint wrap_acc(input longint v);
      logic [ACC_W-1:0] t;
      t = v[ACC_W-1:0];
      return longint'($signed(t));
   endfunction

   task automatic model_reset();
      for (int k = 0; k < SEG_N; k++) mref[k] = (k % 2 == 0) ? ONE_Q : NEG_ONE_Q;
      midx = 0;
      macc = 0;
      msat = 1'b0;
   endtask

   // One accepted segment: product against the table as it stood before this edge.
   task automatic model_accept(input longint d);
      longint p;
      longint s;
      p = (d * mref[midx]) >>> FRAC_W;
      s = macc + p;
`ifdef DEMOD_SAT_EN
      if (s > ACC_MAX) begin s = ACC_MAX; msat = 1'b1; end
      else if (s < ACC_MIN) begin s = ACC_MIN; msat = 1'b1; end
      macc = s;
`else
      macc = wrap_acc(s);
`endif
      if (midx == SEG_N - 1) begin
         exp_q.push_back('{acc: macc, b: (macc > mthresh), sat: msat});
         n_pushed++;
         macc = 0;
         msat = 1'b0;
         midx = 0;
      end else begin
         midx++;
      end
   endtask

   function automatic logic [31:0] rnd_q();
      int v;
      if ($urandom_range(0, 4) == 0) v = int'($urandom);
      else v = int'($urandom_range(0, 32'h000F_FFFF)) - 32'sh0008_0000;
      return v;
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b0;
         in_data  = $urandom;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic ref_write(input int a, input logic [31:0] wd);
      in_valid  = 1'b0;
      ref_we    = 1'b1;
      ref_addr  = AW'(a);
      ref_wdata = wd;
      @(posedge clk);
      mref[a] = longint'($signed(wd));
      #1;
      ref_we = 1'b0;
   endtask

   // Presents one segment until accepted; junk data while not ready must be ignored.
   task automatic send_seg(input logic [31:0] d, input bit wr, input int waddr,
                           input logic [31:0] wd);
      bit rdy;
      bit first;
      int budget;
      first  = 1'b1;
      budget = 0;
      rdy    = 1'b0;
      while (!rdy) begin
         rdy      = in_ready;
         in_valid = 1'b1;
         in_data  = rdy ? d : $urandom;
         ref_we   = first && wr;
         if (first && wr) begin
            ref_addr  = AW'(waddr);
            ref_wdata = wd;
         end
         @(posedge clk);
         if (rdy) model_accept(longint'($signed(d)));
         if (first && wr) mref[waddr] = longint'($signed(wd));
         #1;
         first = 1'b0;
         ref_we = 1'b0;
         budget++;
         if (!rdy && budget > 200) begin
            chk("in_ready_timeout", 0, 1);
            rdy = 1'b1;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_ready();
      int b;
      b = 0;
      while (!in_ready && b < 300) begin
         @(posedge clk);
         #1;
         b++;
      end
      if (!in_ready) chk("wait_in_ready_timeout", 0, 1);
   endtask

   task automatic send_symbol(input logic [31:0] d [SEG_N], input longint th,
                              input int wr_at, input int waddr, input logic [31:0] wd,
                              input bit gaps);
      wait_ready();
      mthresh = th;
      thresh  = th[ACC_W-1:0];
      for (int i = 0; i < SEG_N; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         send_seg(d[i], (i == wr_at), waddr, wd);
      end
   endtask

   task automatic wait_drain();
      int b;
      b = 0;
      while ((exp_q.size() != 0 || out_valid) && b < 500) begin
         @(posedge clk);
         #1;
         b++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
   endtask

   // out_ready: random backpressure unless a test holds it low.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: every presented cycle must match the queue head; pop on handshake.
   always @(negedge clk) begin
      if (!reset && out_valid) begin
         chk("in_ready_low_while_out", longint'(in_ready), 0);
         if (exp_q.size() == 0) begin
            chk("unexpected_symbol", 1, 0);
         end else begin
            chk("out_acc", longint'($signed(out_acc)), exp_q[0].acc);
            chk("out_bit", longint'(out_bit), longint'(exp_q[0].b));
            chk("out_sat", longint'(out_sat), longint'(exp_q[0].sat));
            if (out_ready) begin
               void'(exp_q.pop_front());
               n_out++;
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d [SEG_N];
      int b;

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      ref_we    = 1'b0;
      ref_addr  = '0;
      ref_wdata = '0;
      thresh    = '0;
      mthresh   = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      chk("rst_in_ready",  longint'(in_ready), 1);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_acc",   longint'(out_acc), 0);
      chk("rst_out_bit",   longint'(out_bit), 0);
      chk("rst_out_sat",   longint'(out_sat), 0);

      // Default table, all +1.0 segments.
      for (int i = 0; i < SEG_N; i++) d[i] = Q1;
      send_symbol(d, 0, -1, 0, '0, 1'b0);

      // Default table, alternating segments, with output held off for a while.
      for (int i = 0; i < SEG_N; i++) d[i] = (i % 2 == 0) ? Q1 : QM1;
      wait_ready();
      hold_ready = 1'b1;
      send_symbol(d, 0, -1, 0, '0, 1'b0);
      b = 0;
      while (!out_valid && b < 50) begin @(posedge clk); #1; b++; end
      if (!out_valid) chk("out_valid_timeout", 0, 1);
      repeat (5) @(posedge clk);
      #1;
      hold_ready = 1'b0;
      send_symbol(d, 0, -1, 0, '0, 1'b0);

      // Reference rewrite, then a write landing on the accept of the same index.
      wait_ready();
      ref_write(3, 32'h0002_0000);
      for (int i = 0; i < SEG_N; i++) d[i] = Q1;
      send_symbol(d, 0, -1, 0, '0, 1'b0);
      wait_ready();
      ref_write(3, QM1);
      send_symbol(d, 0, 3, 3, 32'h0002_0000, 1'b0);
      wait_drain();

      // Reset after a partial symbol, then a clean alternating symbol.
      wait_ready();
      mthresh = 0;
      thresh  = '0;
      for (int i = 0; i < 4; i++) send_seg(QM1, 1'b0, 0, '0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      chk("rst2_in_ready",  longint'(in_ready), 1);
      chk("rst2_out_valid", longint'(out_valid), 0);
      for (int i = 0; i < SEG_N; i++) d[i] = (i % 2 == 0) ? Q1 : QM1;
      send_symbol(d, 0, -1, 0, '0, 1'b0);
      wait_drain();
      chk("symbols_after_reset", n_out, n_pushed);

      // Full-scale references and data.
      for (int k = 0; k < SEG_N; k++) ref_write(k, 32'h7FFF_FFFF);
      for (int i = 0; i < SEG_N; i++) d[i] = 32'h7FFF_FFFF;
      send_symbol(d, 0, -1, 0, '0, 1'b0);
      for (int i = 0; i < SEG_N; i++) d[i] = 32'h8000_0001;
      send_symbol(d, -5, -1, 0, '0, 1'b0);

      // Randomised symbols with gaps, backpressure, thresholds and table writes.
      for (int k = 0; k < SEG_N; k++) ref_write(k, rnd_q());
      for (int s = 0; s < 30; s++) begin
         for (int i = 0; i < SEG_N; i++) d[i] = rnd_q();
         send_symbol(d, longint'(int'($urandom_range(0, 32'h0080_0000)) - 32'sh0040_0000),
                     int'($urandom_range(0, 2 * SEG_N)), int'($urandom_range(0, SEG_N - 1)),
                     rnd_q(), 1'b1);
         if ($urandom_range(0, 3) == 0) begin
            idle(1);
            ref_write(int'($urandom_range(0, SEG_N - 1)), rnd_q());
         end
      end

      wait_drain();
      chk("queue_empty", exp_q.size(), 0);
      chk("symbol_count", n_out, n_pushed);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
